m68k_bus_ctrl: RTL
==================

Name: m68k_bus_ctrl

Overview:
- Bus controller between the fx68k core and the system memory/IO.
- Generates the enPhi1/enPhi2 clock enables that pace the CPU.
- Turns ASn/UDSn/LDSn/eRWn cycles into single-cycle memory requests (BRAM or SDRAM port A) and returns DTACKn, VPAn and BERRn.
- Owns a small IO page: LED register, diagnostic register and tick counter. It replaces the constant dtack/vpa/berr ties at the top level.

Parameters:
- c_phi_div, 2: clk cycles per CPU half-phase; must be >= 2.
- c_io_page, 8'hFF: value of cpu_a[23:16] that selects the IO page.
- c_timeout, 255: clk cycles to wait for mem_ack before bus error; 8-bit.

Ports:
- clk  in  1  system clock (25 MHz)
- reset  in  1  asynchronous, active-high
- phi1  out  1  enPhi1 pulse to fx68k
- phi2  out  1  enPhi2 pulse to fx68k
- cpu_as_n  in  1  address strobe
- cpu_rw  in  1  1 = read, 0 = write
- cpu_uds_n  in  1  upper data strobe
- cpu_lds_n  in  1  lower data strobe
- cpu_fc  in  3  function code {FC2,FC1,FC0}
- cpu_a  in  23  word address [23:1]
- cpu_dout  in  16  write data from CPU
- cpu_din  out  16  read data to CPU
- dtack_n  out  1  data transfer acknowledge
- vpa_n  out  1  valid peripheral address (autovector)
- berr_n  out  1  bus error
- mem_rd  out  1  one-cycle read request
- mem_wr  out  1  one-cycle write request
- mem_be  out  2  byte enables {upper,lower}, active-high
- mem_addr  out  23  word address, registered copy of cpu_a
- mem_din  out  16  write data, registered copy of cpu_dout
- mem_dout  in  16  read data from memory
- mem_ack  in  1  memory completion; data valid when asserted
- leds  out  8  LED register
- diag16  out  16  diagnostic register

Behaviour:
- Reset values: phi1=0, phi2=0, dtack_n=1, vpa_n=1, berr_n=1, mem_rd=0, mem_wr=0, mem_be=0, mem_addr=0, mem_din=0, cpu_din=0, leds=0, diag16=0, tick=0, phase counter=0, FSM=IDLE.
- Phase counter: runs 0..2*c_phi_div-1 and wraps.
  - phi1=1 for exactly one clk when count==0.
  - phi2=1 for exactly one clk when count==c_phi_div.
  - phi1 and phi2 are never high together.
- tick: 16-bit counter, increments on every phi1 pulse, wraps FFFF->0000.
- FSM states: IDLE, DECODE, MEM, IO, IACK, ACK, ERR.
- IDLE: on cpu_as_n==0 with (uds_n==0 or lds_n==0), or with cpu_fc==3'b111, latch address, data, byte enables and rw; go to DECODE.
- DECODE:
  - cpu_fc==7: go to IACK.
  - Else cpu_a[23:16]==c_io_page: go to IO.
  - Else pulse mem_rd (rw=1) or mem_wr (rw=0) for one clk; go to MEM.
- MEM:
  - Timeout counter starts at 0.
  - On mem_ack: on a read, latch cpu_din<=mem_dout; go to ACK.
  - If the counter reaches c_timeout without mem_ack: go to ERR.
- IO: decode on byte offset {cpu_a[15:1],0}.
  - 0x0000: write sets leds<=cpu_dout[7:0] if LDS active; read returns {8'h00,leds}.
  - 0x0002: write updates diag16 per byte enable; read returns diag16.
  - 0x0004: read only, returns tick; write ignored but acknowledged.
  - Any other offset: go to ERR.
  - Mapped offsets go to ACK one clk after entering IO.
- IACK: vpa_n<=0; hold until cpu_as_n==1, then vpa_n<=1 and go to IDLE.
- ACK: dtack_n<=0; hold until cpu_as_n==1, then dtack_n<=1 and go to IDLE. Deassertion is registered, one clk after AS rises.
- ERR: berr_n<=0; hold until cpu_as_n==1, then berr_n<=1 and go to IDLE.
- A mem_ack arriving outside MEM is ignored.
- cpu_as_n rising while in DECODE or MEM (aborted cycle): abandon the cycle, return to IDLE, raise no ack. An outstanding mem_ack is discarded.
- Asynchronous reset at any time forces all reset values; a pending memory request is dropped.
- dtack_n, vpa_n and berr_n are mutually exclusive at all times.

Test Plan:
- Phase timing: release reset with c_phi_div=2 -> phi1 at clk 0,4,8,...; phi2 at clk 2,6,10,...; never coincident; tick=3 after 3 phi1 pulses.
- Memory read: AS low, rw=1, a=0x000100, UDS/LDS low; model acks 3 clk after mem_rd with 0xBEEF -> one mem_rd pulse, mem_addr=0x000100, mem_be=2'b11; dtack_n low one clk after ack; cpu_din=0xBEEF; dtack_n high one clk after AS high.
- Byte write to LED: write 0x00A5 to 0xFF0000 with only LDS active -> no mem_wr; leds=0xA5; dtack_n asserted; readback at 0xFF0000 returns 0x00A5.
- Timeout: memory read with mem_ack never asserted -> berr_n low at clk c_timeout after MEM entry, dtack_n stays high; berr_n releases after AS high.
- Unmapped IO and IACK: read 0xFF0010 -> berr_n low; cycle with fc=3'b111 -> vpa_n low, no mem_rd.
- Reset mid-cycle: assert reset while in MEM -> all outputs return to reset values immediately; a later mem_ack causes no dtack.

Source files
------------

// File: rtl/m68k_bus_ctrl.sv
// m68k_bus_ctrl: fx68k bus controller with phase enables, memory bridge and IO page.
// Generates enPhi1/enPhi2, turns AS/UDS/LDS cycles into one-cycle memory
// requests, answers with DTACK/VPA/BERR and owns the LED/diag/tick IO page.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   phi1, phi2            one-clk enPhi1/enPhi2 pulses to the core
//   cpu_as_n .. cpu_dout  CPU bus inputs (strobes, rw, fc, word address, data)
//   cpu_din               read data returned to the CPU
//   dtack_n/vpa_n/berr_n  cycle termination, mutually exclusive
//   mem_rd/mem_wr         one-clk request pulses to memory
//   mem_be/addr/din       latched byte enables, word address and write data
//   mem_dout, mem_ack     memory read data and completion
//   leds, diag16          IO page registers

module m68k_bus_ctrl #(
    parameter int         c_phi_div = 2,
    parameter logic [7:0] c_io_page = 8'hFF,
    parameter int         c_timeout = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        phi1,
    output logic        phi2,
    input  logic        cpu_as_n,
    input  logic        cpu_rw,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic [2:0]  cpu_fc,
    input  logic [23:1] cpu_a,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        dtack_n,
    output logic        vpa_n,
    output logic        berr_n,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  mem_be,
    output logic [23:1] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    input  logic        mem_ack,
    output logic [7:0]  leds,
    output logic [15:0] diag16
);

    localparam int          PH_N    = 2 * c_phi_div;
    localparam int          CW      = $clog2(PH_N);
    localparam logic [CW-1:0] PH_LAST = CW'(PH_N - 1);
    localparam logic [CW-1:0] PH_TWO  = CW'(c_phi_div);
    localparam logic [7:0]  TO_LAST = 8'(c_timeout - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_MEM,
        S_IO,
        S_IACK,
        S_ACK,
        S_ERR
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] ph_cnt;
    logic [15:0]   tick;
    logic [7:0]    tcnt;
    logic          rw_q;
    logic [2:0]    fc_q;

    logic          start;
    logic          is_iack;
    logic          io_hit;
    logic [14:0]   io_off;
    logic          io_led;
    logic          io_diag;
    logic          io_tick;
    logic          io_mapped;
    logic [15:0]   io_rdata;

    // ------------------------------------------------------------------
    // Phase generator and tick counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_cnt <= '0;
            phi1   <= 1'b0;
            phi2   <= 1'b0;
            tick   <= '0;
        end else begin
            if (ph_cnt == PH_LAST)
                ph_cnt <= '0;
            else
                ph_cnt <= ph_cnt + CW'(1);
            phi1 <= (ph_cnt == '0);
            phi2 <= (ph_cnt == PH_TWO);
            // tick advances on the same edge that raises phi1
            if (ph_cnt == '0)
                tick <= tick + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Cycle start and IO page decode (from latched address)
    // ------------------------------------------------------------------
    assign is_iack = (cpu_fc == 3'b111);
    assign start   = !cpu_as_n &&
                     (!cpu_uds_n || !cpu_lds_n || is_iack);

    assign io_hit    = (mem_addr[23:16] == c_io_page);
    assign io_off    = mem_addr[15:1];
    assign io_led    = (io_off == 15'd0);
    assign io_diag   = (io_off == 15'd1);
    assign io_tick   = (io_off == 15'd2);
    assign io_mapped = io_led || io_diag || io_tick;

    always_comb begin
        io_rdata = '0;
        unique case (1'b1)
            io_led:  io_rdata = {8'h00, leds};
            io_diag: io_rdata = diag16;
            io_tick: io_rdata = tick;
            default: io_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start)
                    nxt = S_DECODE;
            end
            S_DECODE: begin
                // AS rising before completion abandons the cycle
                if (cpu_as_n)
                    nxt = S_IDLE;
                else if (fc_q == 3'b111)
                    nxt = S_IACK;
                else if (io_hit)
                    nxt = S_IO;
                else
                    nxt = S_MEM;
            end
            S_MEM: begin
                if (cpu_as_n)
                    nxt = S_IDLE;
                else if (mem_ack)
                    nxt = S_ACK;
                else if (tcnt == TO_LAST)
                    nxt = S_ERR;
            end
            S_IO: begin
                nxt = io_mapped ? S_ACK : S_ERR;
            end
            S_IACK, S_ACK, S_ERR: begin
                if (cpu_as_n)
                    nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dtack_n  <= 1'b1;
            vpa_n    <= 1'b1;
            berr_n   <= 1'b1;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_be   <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            cpu_din  <= '0;
            rw_q     <= 1'b1;
            fc_q     <= '0;
            tcnt     <= '0;
        end else begin
            // terminations follow the next state, so each is
            // asserted on state entry and released on exit
            dtack_n <= (nxt != S_ACK);
            vpa_n   <= (nxt != S_IACK);
            berr_n  <= (nxt != S_ERR);

            mem_rd <= (state == S_DECODE) &&
                      (nxt == S_MEM) && rw_q;
            mem_wr <= (state == S_DECODE) &&
                      (nxt == S_MEM) && !rw_q;

            if (state == S_IDLE && start) begin
                mem_addr <= cpu_a;
                mem_din  <= cpu_dout;
                mem_be   <= {!cpu_uds_n, !cpu_lds_n};
                rw_q     <= cpu_rw;
                fc_q     <= cpu_fc;
            end

            if (state == S_MEM)
                tcnt <= tcnt + 8'd1;
            else
                tcnt <= '0;

            if (state == S_MEM && nxt == S_ACK && rw_q)
                cpu_din <= mem_dout;

            if (state == S_IO && rw_q && io_mapped)
                cpu_din <= io_rdata;
        end
    end

    // ------------------------------------------------------------------
    // IO page registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds   <= '0;
            diag16 <= '0;
        end else if (state == S_IO && !rw_q) begin
            if (io_led && mem_be[0])
                leds <= mem_din[7:0];
            if (io_diag && mem_be[1])
                diag16[15:8] <= mem_din[15:8];
            if (io_diag && mem_be[0])
                diag16[7:0] <= mem_din[7:0];
        end
    end

endmodule
